mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 42 ++++
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the LC-3b datapath and mem_responder.
// MEM_RESPONDER_ALIGN_CHECK_EN adds the mem_err misalignment flag.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic        mem_err;
`endif

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        ,
        input  mem_err
`endif
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        ,
        output mem_err
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder for the LC-3b memory interface.
// Optional MEM_RESPONDER_ALIGN_CHECK_EN flags misaligned accesses on mem_err.
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_responder_if.slave   bus
);
    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    function automatic logic [15:0] merge_lanes(
        input logic [15:0] old_word,
        input logic [15:0] new_word,
        input logic [1:0]  lanes
    );
        logic [15:0] res;
        res[7:0]  = lanes[0] ? new_word[7:0]  : old_word[7:0];
        res[15:8] = lanes[1] ? new_word[15:8] : old_word[15:8];
        return res;
    endfunction

    function automatic logic is_misaligned(
        input logic       is_write,
        input logic [1:0] lanes,
        input logic       addr_lsb
    );
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        logic res;
        if (is_write) begin
            res = addr_lsb & (lanes == 2'b11);
        end else begin
            res = addr_lsb;
        end
        return res;
`else
        return 1'b0 & is_write & (^lanes) & addr_lsb;
`endif
    endfunction

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 op_wr_q, op_wr_d;
    logic                 resp_q, resp_d;
    logic                 err_q, err_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [15:0]          mem_q [DEPTH];

    logic                 req_s;
    logic                 enter_resp_s;
    logic                 wr_s;
    logic                 mis_s;
    logic                 do_write_s;
    logic [ADDR_BITS-1:0] idx_s;
    logic                 unused_s;

    assign req_s    = bus.mem_read | bus.mem_write;
    assign idx_s    = bus.mem_address[ADDR_BITS:1];
    assign unused_s = ^(bus.mem_address >> (ADDR_BITS + 1)) ^ bus.mem_address[0];

    // Transaction sequencing: accept, count down latency, abort on dropped request.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_wr_d      = op_wr_q;
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    op_wr_d = bus.mem_write;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d      = ST_RESP;
                    cnt_d        = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                op_wr_d = 1'b0;
            end
        endcase
    end

    // Response datapath: address, data and lanes are taken live on the RESP entry edge.
    always_comb begin
        if (state_q == ST_IDLE) begin
            wr_s = bus.mem_write;
        end else begin
            wr_s = op_wr_q;
        end
        mis_s      = is_misaligned(wr_s, bus.mem_byte_enable, bus.mem_address[0]);
        resp_d     = enter_resp_s;
        err_d      = enter_resp_s & mis_s;
        do_write_s = enter_resp_s & wr_s & ~mis_s & reset_n;
        rdata_d    = rdata_q;
        if (enter_resp_s && !wr_s) begin
            if (mis_s) begin
                rdata_d = 16'h0000;
            end else begin
                rdata_d = mem_q[idx_s];
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_q[idx_s] <= merge_lanes(mem_q[idx_s], bus.mem_wdata, bus.mem_byte_enable);
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign bus.mem_err   = err_q;
`else
    logic unused_err_s;
    assign unused_err_s = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
module tb_mem_responder;
    localparam int AB  = 8;
    localparam int LAT = 3;
    localparam int NW  = 1 << AB;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [15:0] model [NW];
    logic [15:0] last_rd;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit misaligned(input bit wr, input logic [1:0] be, input logic [15:0] addr);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        return addr[0] && (wr ? (be == 2'b11) : 1'b1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wd);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_address     = addr;
        bus.mem_wdata       = wd;
    endtask

    // Starts in an IDLE cycle (just after an edge) and ends in the next IDLE cycle.
    task automatic txn(input bit rd, input bit wr, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wd, input string tag);
        int waited;
        int idx;
        bit mis;
        drive(rd, wr, be, addr, wd);
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!bus.mem_resp && waited < 20);
        chk({tag, "_lat"}, waited, LAT);
        idx = (addr / 2) % NW;
        mis = misaligned(wr, be, addr);
        if (wr) begin
            if (!mis) begin
                if (be[0]) model[idx][7:0]  = wd[7:0];
                if (be[1]) model[idx][15:8] = wd[15:8];
            end
        end else begin
            last_rd = mis ? 16'h0000 : model[idx];
        end
        chk({tag, "_rdata"}, bus.mem_rdata, last_rd);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        chk({tag, "_err"}, bus.mem_err, mis);
`endif
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, bus.mem_resp, 1'b0);
    endtask

    initial begin
        int nresp;
        int prev;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] old20;

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        last_rd = 16'h0000;
        #12;
        chk("rst_resp", bus.mem_resp, 1'b0);
        chk("rst_rdata", bus.mem_rdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < NW; i++) begin
            d = 16'($urandom);
            a = 16'(i * 2);
            drive(1'b0, 1'b1, 2'b11, a, d);
            txn(1'b0, 1'b1, 2'b11, a, d, "fill");
        end

        txn(1'b0, 1'b1, 2'b11, 16'h0010, 16'h1234, "w1234");
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "r1234");
        chk("plan_1234", bus.mem_rdata, 16'h1234);
        txn(1'b0, 1'b1, 2'b01, 16'h0010, 16'h00AB, "wlo");
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "rlo");
        chk("plan_12ab", bus.mem_rdata, 16'h12AB);
        txn(1'b0, 1'b1, 2'b10, 16'h0010, 16'hCD00, "whi");
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "rhi");
        chk("plan_cdab", bus.mem_rdata, 16'hCDAB);
        txn(1'b1, 1'b0, 2'b00, 16'h0210, 16'h0000, "alias");
        chk("plan_alias", bus.mem_rdata, 16'hCDAB);
        txn(1'b1, 1'b0, 2'b00, 16'h0011, 16'h0000, "odd_rd");
        txn(1'b1, 1'b1, 2'b11, 16'h0040, 16'hBEEF, "both");
        txn(1'b0, 1'b1, 2'b00, 16'h0040, 16'h0000, "be00");
        txn(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, "rboth");
        chk("plan_both", bus.mem_rdata, 16'hBEEF);

        // Abort: write held two cycles then dropped.
        drive(1'b0, 1'b1, 2'b11, 16'h0010, 16'h5555);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.mem_resp) nresp++;
            @(posedge clk); #1;
        end
        chk("abort_noresp", nresp, 0);
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "abort_rd");
        chk("abort_old", bus.mem_rdata, 16'hCDAB);

        // Back-to-back reads with the request held.
        drive(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
        nresp = 0;
        prev  = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin
                if (prev > 0) chk("b2b_gap", c - prev, LAT + 1);
                else chk("b2b_first", c, LAT);
                chk("b2b_rdata", bus.mem_rdata, model[8]);
                prev = c;
                nresp++;
            end
        end
        chk("b2b_count", nresp, 3);
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        @(posedge clk); #1;

        // Reset during the WAIT of a write.
        old20 = model[16];
        drive(1'b0, 1'b1, 2'b11, 16'h0020, ~old20);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_resp", bus.mem_resp, 1'b0);
        chk("mrst_rdata", bus.mem_rdata, 16'h0000);
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        last_rd = 16'h0000;
        chk("mrst_post_resp", bus.mem_resp, 1'b0);
        chk("mrst_post_rdata", bus.mem_rdata, 16'h0000);
        txn(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, "mrst_rd");
        chk("mrst_old", bus.mem_rdata, old20);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        txn(1'b0, 1'b1, 2'b11, 16'h0011, 16'h9999, "mis_wr");
        txn(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, "mis_chk");
        chk("mis_unchanged", bus.mem_rdata, 16'hCDAB);
`endif

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 2));
            a  = 16'($urandom);
            d  = 16'($urandom);
            txn(op != 1, op != 0, 2'($urandom), a, d, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
